// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_pkg : shared RV32I pipeline types, opcodes and defaults           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_HALT   = 7'b1111111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Masking rather than slicing keeps every bit of the operand in use.
  function automatic logic [31:0] align_pc(input logic [31:0] p);
    return p & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_reg : program counter with reset / hold / load / increment        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (hold) begin
      pc_d = pc_q;
    end else if (load) begin
      pc_d = align_pc(load_pc);
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : RV32I IF stage with IF/ID register, stall, redirect    |
// |               flush and sticky halt                      rev 1.0     |
// +----------------------------------------------------------------------+
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          IMEM_AW   = 9,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_com,
  input  logic [31:0]        imem_rdata,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_d, state_q;
  if_id_t       if_id_d, if_id_q;
  logic [31:0]  count_d, count_q;
  logic         halt_take;
  logic         pc_hold;
  logic         pc_load;

  // A HALT seen alongside a taken redirect is on the wrong path and is dropped.
  assign halt_take = (state_q == ST_HALT) || (halt_com && !redirect);
  assign pc_hold   = halt_take || (stall && !redirect);
  assign pc_load   = redirect && !halt_take;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .hold    (pc_hold),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    count_d = count_q;
    if (halt_take) begin
      state_d       = ST_HALT;
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (redirect) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!stall) begin
      if_id_d.pc    = pc;
      if_id_d.instr = imem_rdata;
      if_id_d.valid = 1'b1;
      count_d       = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      if_id_q.pc    <= 32'h0000_0000;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
      count_q       <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc[IMEM_AW+1:2];
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage : directed + random stimulus against a reference model|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

  localparam int          IMEM_AW = 9;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               halt_com;
  logic [31:0]        imem_rdata;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc;
  logic [31:0]        if_id_pc;
  logic [31:0]        if_id_instr;
  logic               if_id_valid;
  logic               halted;
  logic [31:0]        fetch_count;

  logic [31:0] mem [0:(1<<IMEM_AW)-1];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_halted;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_AW   (IMEM_AW),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_com    (halt_com),
    .imem_rdata  (imem_rdata),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  initial begin
    for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'h1000_0000 + i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the spec's per-edge rules applied to plain variables.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halted = 1'b0; m_cnt = 32'h0;
    end else if (m_halted || (halt_com && !redirect)) begin
      m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_ipc = m_pc;
      m_instr = 32'h1000_0000 + ((m_pc / 4) % (1 << IMEM_AW));
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", {23'h0, imem_addr}, (m_pc / 4) % (1 << IMEM_AW));
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
      chk("fetch_count", fetch_count, m_cnt);
    end
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [31:0] rp, input logic h);
    reset = r; stall = s; redirect = rd; redirect_pc = rp; halt_com = h;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt_com = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 32'h0, 0);
    chk_en = 1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);

    // Free run
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 32'h0, 0);
      chk("run_pc", pc, 32'h4 * (i + 1));
      chk("run_instr", if_id_instr, 32'h1000_0000 + i);
    end
    chk("run_count", fetch_count, 32'd4);

    // Stall at pc=8
    cyc(1, 0, 0, 32'h0, 0);
    run(2);
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_instr", if_id_instr, 32'h1000_0001);
    chk("stall_count", fetch_count, 32'd2);
    run(1);
    chk("unstall_ipc", if_id_pc, 32'h8);
    chk("unstall_instr", if_id_instr, 32'h1000_0002);

    // Redirect to misaligned target
    cyc(0, 0, 1, 32'h0000_0043, 0);
    chk("redir_pc", pc, 32'h40);
    chk("redir_instr", if_id_instr, NOP);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    run(1);
    chk("redir_ipc", if_id_pc, 32'h40);
    chk("redir_word", if_id_instr, 32'h1000_0010);

    // Redirect beats stall
    cyc(0, 1, 1, 32'h0000_0080, 0);
    chk("redir_stall_pc", pc, 32'h80);
    chk("redir_stall_valid", {31'h0, if_id_valid}, 32'h0);

    // Halt at pc=0x10
    cyc(1, 0, 0, 32'h0, 0);
    run(4);
    cyc(0, 0, 0, 32'h0, 1);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h10);
    cyc(0, 0, 1, 32'h0000_0200, 0);
    cyc(0, 1, 0, 32'h0, 0);
    run(3);
    chk("halt_hold_pc", pc, 32'h10);
    chk("halt_valid", {31'h0, if_id_valid}, 32'h0);
    chk("halt_count", fetch_count, 32'd4);
    cyc(1, 0, 0, 32'h0, 0);
    chk("unhalt_flag", {31'h0, halted}, 32'h0);
    chk("unhalt_pc", pc, 32'h0);

    // Halt and redirect together: redirect wins
    cyc(0, 0, 1, 32'h0000_0200, 1);
    chk("halt_redir_flag", {31'h0, halted}, 32'h0);
    chk("halt_redir_pc", pc, 32'h200);

    // PC wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    run(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_ipc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", if_id_instr, 32'h1000_01FF);
    chk("wrap_count", fetch_count, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          $urandom, ($urandom_range(39) == 0));
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline; sits directly upstream of the decode stage and its opcode controller.
- Owns the PC register and drives the instruction-memory address.
- Registers {PC, instruction} into the IF/ID pipeline register, whose instr[6:0] field is the Opcode consumed by decode.
- Handles load-use stall, branch/jump redirect with flush, and sticky halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 9, instruction-memory word-address width.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  branch unit: taken branch/jump resolved in EX.
- redirect_pc  in  32  target PC for redirect.
- halt_com  in  1  HALT opcode decoded in ID.
- imem_rdata  in  32  instruction word; combinational read of imem_addr, same cycle.
- imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
- pc  out  32  current fetch PC.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID; [6:0] feeds the decode Opcode.
- if_id_valid  out  1  IF/ID holds a real fetched instruction (0 = bubble).
- halted  out  1  sticky halt status.
- fetch_count  out  32  count of valid instructions written into IF/ID.

Behaviour:
- Reset, synchronous:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_instr = NOP_INSTR, if_id_valid = 0
  - halted = 0, fetch_count = 0
- Reset overrides every other input in the same cycle.
- Latency: the instruction at PC appears in IF/ID on the next rising edge.
- Per-edge priority (first matching rule applies):
  1. reset: as above.
  2. halted=1, or halt_com=1 and redirect=0:
     - halted <= 1; pc holds.
     - IF/ID <= bubble (NOP_INSTR, valid 0, if_id_pc holds).
     - fetch_count holds.
  3. redirect=1:
     - pc <= {redirect_pc[31:2], 2'b00}; IF/ID <= bubble (flush).
     - Wins over stall and over halt_com, because a HALT in ID behind a taken branch is wrong-path.
  4. stall=1: pc, IF/ID and fetch_count all hold.
  5. Normal:
     - pc <= pc + 4, wrapping modulo 2^32.
     - if_id_pc <= pc; if_id_instr <= imem_rdata; if_id_valid <= 1.
     - fetch_count <= fetch_count + 1, wrapping modulo 2^32.
- State machine, 2 states:
  - RUN -> HALT on rule 2.
  - HALT -> RUN only on reset.
  - halted is the encoded state.
- Once halted, stall and redirect are ignored.
- pc[1:0] is always 00; imem address wraps naturally at 2^IMEM_AW words.
- Reset asserted mid-stall or mid-halt returns to RUN at RESET_PC on the next edge.
- All outputs are registered except imem_addr, which is a combinational slice of pc.

Decomposition:
- Shared package rv_pkg holds:
  - NOP_INSTR and RESET_PC defaults
  - opcode constants: OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_IMM, OPC_JAL, OPC_JALR, OPC_HALT
  - packed struct if_id_t {pc, instr, valid}
- The decode controller also switches to the rv_pkg opcode constants.
- One sub-module, pc_reg: PC register with reset/hold/load/increment.
- The IF/ID register and halt FSM live in fetch_stage.

Test Plan:
- Reset then 4 free-run cycles, imem[i] = 32'h1000_0000+i:
  - pc steps 0, 4, 8, C, 10.
  - if_id_instr = 32'h1000_0000..0003 with valid 1.
  - fetch_count = 4.
- stall held 2 cycles at pc=8:
  - pc stays 8; IF/ID holds the word from pc 4; fetch_count unchanged.
  - Release: fetch resumes at 8.
- redirect with redirect_pc = 32'h0000_0043:
  - Next edge pc = 32'h40; IF/ID = NOP_INSTR, valid 0.
  - Following edge: IF/ID holds the word at 0x40.
- redirect and stall asserted together: redirect wins, pc = target, IF/ID flushed.
- halt_com pulse at pc=0x10:
  - halted = 1 and pc frozen at 0x10 indefinitely; IF/ID stays a bubble.
  - Later redirect/stall have no effect.
  - Reset restores pc = 0, halted = 0.
- halt_com and redirect same cycle: halted stays 0 and pc = target.
- pc = 32'hFFFF_FFFC free-run: pc wraps to 0 and fetch_count increments.
